// File: rtl/nubus_cpu_arbiter.sv
// rtl/nubus_cpu_arbiter.sv - round-robin arbiter of NCH requesters onto one NuBus CPU master port
module nubus_cpu_arbiter #(
    parameter int NCH       = 4,
    parameter int TIMEOUT   = 255,
    parameter int LOCK_HOLD = 15
) (
    input  logic                     nub_clkn,
    input  logic                     nub_resetn,
    input  logic [NCH-1:0]           ch_valid,
    input  logic [NCH*32-1:0]        ch_addr,
    input  logic [NCH*32-1:0]        ch_wdata,
    input  logic [NCH*4-1:0]         ch_write,
    input  logic [NCH-1:0]           ch_lock,
    output logic [NCH-1:0]           ch_ready,
    output logic                     ch_err,
    output logic [31:0]              ch_rdata,
    output logic                     cpu_valid,
    output logic [31:0]              cpu_addr,
    output logic [31:0]              cpu_wdata,
    output logic [3:0]               cpu_write,
    output logic                     cpu_lock,
    input  logic                     cpu_ready,
    input  logic [31:0]              cpu_rdata,
    output logic [$clog2(NCH)-1:0]   grant
);

    localparam int GW  = $clog2(NCH);
    localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int HCW = (LOCK_HOLD > 0) ? $clog2(LOCK_HOLD + 1) : 1;
    // Abort fires on the edge where the wait count would reach TIMEOUT.
    localparam logic [WCW-1:0] TO_LAST   = (TIMEOUT > 0) ? WCW'(TIMEOUT - 1) : '0;
    localparam logic [HCW-1:0] HOLD_LAST = (LOCK_HOLD > 0) ? HCW'(LOCK_HOLD - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic             cpu_valid_q, cpu_valid_d;
    logic [31:0]      cpu_addr_q, cpu_addr_d;
    logic [31:0]      cpu_wdata_q, cpu_wdata_d;
    logic [3:0]       cpu_write_q, cpu_write_d;
    logic             cpu_lock_q, cpu_lock_d;
    logic [NCH-1:0]   ch_ready_q, ch_ready_d;
    logic             ch_err_q, ch_err_d;
    logic [31:0]      ch_rdata_q, ch_rdata_d;
    logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;

    logic             sel_found;
    logic [GW-1:0]    sel_idx;
    logic [GW-1:0]    load_idx;
    logic [31:0]      load_addr;
    logic [31:0]      load_wdata;
    logic [3:0]       load_write;
    logic             load_lock;
    logic             ready_hit;
    logic             timeout_hit;
    logic             issue_start;

    // Cyclic search: lowest requester at/after rr_ptr, else lowest requester overall.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (ch_valid[j]) begin
                sel_found = 1'b1;
                sel_idx   = GW'(j);
            end
        end
        for (int j = NCH - 1; j >= 0; j--) begin
            if (ch_valid[j] && (GW'(j) >= rr_ptr_q)) begin
                sel_idx = GW'(j);
            end
        end
    end

    // Request fields of the channel about to be issued (new winner, or the locked owner).
    always_comb begin
        load_idx   = (state_q == S_HOLD) ? grant_q : sel_idx;
        load_addr  = '0;
        load_wdata = '0;
        load_write = '0;
        load_lock  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (GW'(i) == load_idx) begin
                load_addr  = ch_addr[32*i +: 32];
                load_wdata = ch_wdata[32*i +: 32];
                load_write = ch_write[4*i +: 4];
                load_lock  = ch_lock[i];
            end
        end
    end

    // Completion events; a cpu_ready with no outstanding request is ignored.
    always_comb begin
        ready_hit   = (state_q == S_ISSUE) && cpu_valid_q && cpu_ready;
        timeout_hit = (TIMEOUT > 0) && (state_q == S_ISSUE) && cpu_valid_q &&
                      !cpu_ready && (wait_cnt_q == TO_LAST);
    end

    // FSM state register.
    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (ready_hit || timeout_hit) state_d = S_DONE;
            end
            S_DONE: begin
                state_d = (cpu_lock_q && !ch_err_q && (LOCK_HOLD > 0)) ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (ch_valid[grant_q]) begin
                    state_d = S_ISSUE;
                end else if (!ch_lock[grant_q] || (hold_cnt_q == HOLD_LAST)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath next values.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        cpu_valid_d = cpu_valid_q;
        cpu_addr_d  = cpu_addr_q;
        cpu_wdata_d = cpu_wdata_q;
        cpu_write_d = cpu_write_q;
        cpu_lock_d  = cpu_lock_q;
        ch_ready_d  = ch_ready_q;
        ch_err_d    = ch_err_q;
        ch_rdata_d  = ch_rdata_q;
        wait_cnt_d  = wait_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        issue_start = (state_d == S_ISSUE) && (state_q != S_ISSUE);

        if (issue_start) begin
            grant_d     = load_idx;
            cpu_valid_d = 1'b1;
            cpu_addr_d  = load_addr;
            cpu_wdata_d = load_wdata;
            cpu_write_d = load_write;
            cpu_lock_d  = load_lock;
            wait_cnt_d  = '0;
        end

        case (state_q)
            S_ISSUE: begin
                if (ready_hit) begin
                    cpu_valid_d = 1'b0;
                    ch_ready_d  = {{(NCH-1){1'b0}}, 1'b1} << grant_q;
                    ch_err_d    = 1'b0;
                    ch_rdata_d  = cpu_rdata;
                end else if (timeout_hit) begin
                    // An aborted transfer also breaks any lock sequence.
                    cpu_valid_d = 1'b0;
                    cpu_lock_d  = 1'b0;
                    ch_ready_d  = {{(NCH-1){1'b0}}, 1'b1} << grant_q;
                    ch_err_d    = 1'b1;
                    ch_rdata_d  = 32'hFFFF_FFFF;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_DONE: begin
                ch_ready_d = '0;
                ch_err_d   = 1'b0;
                rr_ptr_d   = (grant_q == GW'(NCH - 1)) ? '0 : grant_q + GW'(1);
                hold_cnt_d = '0;
            end
            S_HOLD: begin
                if (!issue_start && (hold_cnt_q != '1)) begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            default: ;
        endcase

        if ((state_d == S_IDLE) && (state_q != S_IDLE)) begin
            cpu_lock_d = 1'b0;
        end
    end

    // Datapath registers.
    always_ff @(posedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            cpu_valid_q <= 1'b0;
            cpu_addr_q  <= '0;
            cpu_wdata_q <= '0;
            cpu_write_q <= '0;
            cpu_lock_q  <= 1'b0;
            ch_ready_q  <= '0;
            ch_err_q    <= 1'b0;
            ch_rdata_q  <= '0;
            wait_cnt_q  <= '0;
            hold_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            cpu_valid_q <= cpu_valid_d;
            cpu_addr_q  <= cpu_addr_d;
            cpu_wdata_q <= cpu_wdata_d;
            cpu_write_q <= cpu_write_d;
            cpu_lock_q  <= cpu_lock_d;
            ch_ready_q  <= ch_ready_d;
            ch_err_q    <= ch_err_d;
            ch_rdata_q  <= ch_rdata_d;
            wait_cnt_q  <= wait_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign ch_ready  = ch_ready_q;
    assign ch_err    = ch_err_q;
    assign ch_rdata  = ch_rdata_q;
    assign cpu_valid = cpu_valid_q;
    assign cpu_addr  = cpu_addr_q;
    assign cpu_wdata = cpu_wdata_q;
    assign cpu_write = cpu_write_q;
    assign cpu_lock  = cpu_lock_q;
    assign grant     = grant_q;

endmodule

// File: tb/tb_nubus_cpu_arbiter.sv
// tb/tb_nubus_cpu_arbiter.sv - directed self-checking bench for nubus_cpu_arbiter
module tb_nubus_cpu_arbiter;

    logic         nub_clkn;
    logic         nub_resetn;
    logic [3:0]   ch_valid;
    logic [127:0] ch_addr;
    logic [127:0] ch_wdata;
    logic [15:0]  ch_write;
    logic [3:0]   ch_lock;
    logic [3:0]   ch_ready;
    logic         ch_err;
    logic [31:0]  ch_rdata;
    logic         cpu_valid;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [3:0]   cpu_write;
    logic         cpu_lock;
    logic         cpu_ready;
    logic [31:0]  cpu_rdata;
    logic [1:0]   grant;

    int           n_cmp;
    int           n_mis;
    logic         slave_en;
    int           slave_lat;
    logic [31:0]  slave_rdata;
    logic         stray_ready;
    int           vcnt;
    int           hi_cnt;

    nubus_cpu_arbiter #(.NCH(4), .TIMEOUT(8), .LOCK_HOLD(15)) dut (
        .nub_clkn   (nub_clkn),
        .nub_resetn (nub_resetn),
        .ch_valid   (ch_valid),
        .ch_addr    (ch_addr),
        .ch_wdata   (ch_wdata),
        .ch_write   (ch_write),
        .ch_lock    (ch_lock),
        .ch_ready   (ch_ready),
        .ch_err     (ch_err),
        .ch_rdata   (ch_rdata),
        .cpu_valid  (cpu_valid),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_write  (cpu_write),
        .cpu_lock   (cpu_lock),
        .cpu_ready  (cpu_ready),
        .cpu_rdata  (cpu_rdata),
        .grant      (grant)
    );

    initial nub_clkn = 1'b0;
    always #5 nub_clkn = ~nub_clkn;

    task automatic tick();
        @(posedge nub_clkn);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int max_cyc);
        int n;
        n = 0;
        while (ch_ready == 4'b0000 && n < max_cyc) begin
            tick();
            n++;
        end
        chk(tag, 32'(ch_ready != 4'b0000), 32'd1);
    endtask

    task automatic do_reset();
        ch_valid   = '0;
        ch_lock    = '0;
        ch_write   = '0;
        nub_resetn = 1'b0;
        tick();
        tick();
        nub_resetn = 1'b1;
        tick();
    endtask

    // Slave: answers cpu_valid after slave_lat cycles when enabled.
    initial begin
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        vcnt      = 0;
        forever begin
            @(posedge nub_clkn);
            #1;
            if (cpu_valid) vcnt++;
            else vcnt = 0;
            cpu_ready = stray_ready || (slave_en && cpu_valid && vcnt >= slave_lat);
            cpu_rdata = slave_rdata;
        end
    end

    initial begin
        n_cmp       = 0;
        n_mis       = 0;
        slave_en    = 1'b0;
        slave_lat   = 3;
        slave_rdata = '0;
        stray_ready = 1'b0;
        ch_valid    = '0;
        ch_addr     = '0;
        ch_wdata    = '0;
        ch_write    = '0;
        ch_lock     = '0;
        nub_resetn  = 1'b0;
        tick();
        tick();
        chk("rst_cpu_valid", 32'(cpu_valid), 32'd0);
        chk("rst_grant",     32'(grant),     32'd0);
        chk("rst_ch_ready",  32'(ch_ready),  32'd0);
        chk("rst_ch_err",    32'(ch_err),    32'd0);
        chk("rst_ch_rdata",  ch_rdata,       32'd0);
        chk("rst_cpu_addr",  cpu_addr,       32'd0);
        chk("rst_cpu_lock",  32'(cpu_lock),  32'd0);
        chk("rst_cpu_write", 32'(cpu_write), 32'd0);
        nub_resetn = 1'b1;
        tick();

        // cpu_ready with no outstanding request
        stray_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("stray_ch_ready",  32'(ch_ready),  32'd0);
        chk("stray_cpu_valid", 32'(cpu_valid), 32'd0);
        stray_ready = 1'b0;
        tick();

        // Single write on channel 1, slave latency 3
        slave_en    = 1'b1;
        slave_lat   = 3;
        slave_rdata = 32'h1234_5678;
        ch_addr[63:32]  = 32'hF000_0000;
        ch_wdata[63:32] = 32'h8765_4321;
        ch_write[7:4]   = 4'b1111;
        ch_valid        = 4'b0010;
        chk("wr_valid_before", 32'(cpu_valid), 32'd0);
        tick();
        chk("wr_cpu_valid", 32'(cpu_valid), 32'd1);
        chk("wr_grant",     32'(grant),     32'd1);
        chk("wr_cpu_addr",  cpu_addr,       32'hF000_0000);
        chk("wr_cpu_wdata", cpu_wdata,      32'h8765_4321);
        chk("wr_cpu_write", 32'(cpu_write), 32'hF);
        chk("wr_cpu_lock",  32'(cpu_lock),  32'd0);
        ch_addr[63:32] = 32'hDEAD_BEEF;
        tick();
        chk("wr_addr_stable", cpu_addr, 32'hF000_0000);
        wait_ready("wr_ready_seen", 20);
        chk("wr_ch_ready",  32'(ch_ready),  32'b0010);
        chk("wr_ch_err",    32'(ch_err),    32'd0);
        chk("wr_valid_drop", 32'(cpu_valid), 32'd0);
        ch_valid = 4'b0000;
        tick();
        chk("wr_ready_one_pulse", 32'(ch_ready), 32'd0);

        // Round-robin: four continuous readers
        do_reset();
        slave_lat = 1;
        ch_write  = '0;
        ch_valid  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            slave_rdata = 32'hA000_0000 + 32'(k);
            wait_ready("rr_ready_seen", 20);
            chk("rr_grant",    32'(grant),    32'(k % 4));
            chk("rr_ch_ready", 32'(ch_ready), 32'(1 << (k % 4)));
            chk("rr_ch_rdata", ch_rdata,      32'hA000_0000 + 32'(k));
            tick();
        end
        ch_valid = 4'b0000;
        tick();
        tick();

        // Locked write then read on channel 1 while ch0 and ch2 wait
        do_reset();
        slave_lat       = 2;
        slave_rdata     = 32'h0BAD_F00D;
        ch_addr[63:32]  = 32'hF000_0004;
        ch_wdata[63:32] = 32'h5555_AAAA;
        ch_write[7:4]   = 4'b1111;
        ch_lock         = 4'b0010;
        ch_valid        = 4'b0010;
        tick();
        chk("lk_grant1",   32'(grant),    32'd1);
        chk("lk_cpu_lock", 32'(cpu_lock), 32'd1);
        ch_valid = 4'b0111;
        wait_ready("lk_wr_seen", 20);
        chk("lk_wr_ready", 32'(ch_ready), 32'b0010);
        ch_write[7:4] = 4'b0000;
        tick();
        chk("lk_hold_lock",  32'(cpu_lock),  32'd1);
        chk("lk_hold_valid", 32'(cpu_valid), 32'd0);
        tick();
        chk("lk_rd_valid", 32'(cpu_valid), 32'd1);
        chk("lk_rd_grant", 32'(grant),     32'd1);
        chk("lk_rd_write", 32'(cpu_write), 32'd0);
        chk("lk_rd_lock",  32'(cpu_lock),  32'd1);
        wait_ready("lk_rd_seen", 20);
        chk("lk_rd_ready", 32'(ch_ready), 32'b0010);
        chk("lk_rd_rdata", ch_rdata,      32'h0BAD_F00D);
        ch_valid = 4'b0101;
        ch_lock  = 4'b0000;
        tick();
        wait_ready("lk_next_seen", 20);
        chk("lk_next_ready", 32'(ch_ready), 32'b0100);
        chk("lk_next_grant", 32'(grant),    32'd2);
        chk("lk_next_lock",  32'(cpu_lock), 32'd0);
        ch_valid = 4'b0000;
        tick();
        tick();

        // Lock expiry after LOCK_HOLD idle cycles; ch0 waits
        do_reset();
        slave_lat     = 2;
        ch_write[7:4] = 4'b1111;
        ch_lock       = 4'b0010;
        ch_valid      = 4'b0010;
        tick();
        wait_ready("lx_seen", 20);
        chk("lx_ready", 32'(ch_ready), 32'b0010);
        ch_valid = 4'b0001;
        for (int h = 1; h <= 15; h++) begin
            tick();
            chk("lx_hold_valid", 32'(cpu_valid), 32'd0);
            chk("lx_hold_lock",  32'(cpu_lock),  32'd1);
        end
        tick();
        chk("lx_idle_lock",  32'(cpu_lock),  32'd0);
        chk("lx_idle_valid", 32'(cpu_valid), 32'd0);
        tick();
        chk("lx_ch0_valid", 32'(cpu_valid), 32'd1);
        chk("lx_ch0_grant", 32'(grant),     32'd0);
        wait_ready("lx_ch0_seen", 20);
        chk("lx_ch0_ready", 32'(ch_ready), 32'b0001);
        ch_valid = 4'b0000;
        ch_lock  = 4'b0000;
        tick();
        tick();

        // Timeout with the slave silent, on a locked request
        do_reset();
        slave_en = 1'b0;
        ch_write = '0;
        ch_lock  = 4'b0100;
        ch_valid = 4'b0100;
        tick();
        chk("to_valid_rise", 32'(cpu_valid), 32'd1);
        hi_cnt = 1;
        for (int w = 0; w < 40 && cpu_valid; w++) begin
            tick();
            if (cpu_valid) hi_cnt++;
        end
        chk("to_valid_cycles", 32'(hi_cnt),   32'd8);
        chk("to_ch_ready",     32'(ch_ready), 32'b0100);
        chk("to_ch_err",       32'(ch_err),   32'd1);
        chk("to_ch_rdata",     ch_rdata,      32'hFFFF_FFFF);
        chk("to_cpu_lock",     32'(cpu_lock), 32'd0);
        ch_valid = 4'b0000;
        tick();
        chk("to_after_err", 32'(ch_err),   32'd0);
        tick();
        chk("to_idle_lock", 32'(cpu_lock), 32'd0);
        ch_lock = 4'b0000;

        // Reset asserted mid-issue; rr_ptr is 3 beforehand
        do_reset();
        slave_en = 1'b1;
        slave_lat = 2;
        ch_valid = 4'b0100;
        tick();
        wait_ready("mr_pre_seen", 20);
        ch_valid = 4'b0000;
        tick();
        slave_en = 1'b0;
        ch_addr[127:96]  = 32'hC000_0010;
        ch_wdata[127:96] = 32'h1111_2222;
        ch_write[15:12]  = 4'b0011;
        ch_valid         = 4'b1000;
        tick();
        tick();
        chk("mr_issue_valid", 32'(cpu_valid), 32'd1);
        nub_resetn = 1'b0;
        #1;
        chk("mr_cpu_valid", 32'(cpu_valid), 32'd0);
        chk("mr_cpu_addr",  cpu_addr,       32'd0);
        chk("mr_cpu_wdata", cpu_wdata,      32'd0);
        chk("mr_cpu_write", 32'(cpu_write), 32'd0);
        chk("mr_grant",     32'(grant),     32'd0);
        chk("mr_ch_ready",  32'(ch_ready),  32'd0);
        ch_valid = 4'b1010;
        tick();
        chk("mr_held_ready", 32'(ch_ready), 32'd0);
        tick();
        nub_resetn = 1'b1;
        slave_en   = 1'b1;
        tick();
        chk("mr_first_valid", 32'(cpu_valid), 32'd1);
        chk("mr_first_grant", 32'(grant),     32'd1);
        wait_ready("mr_first_seen", 20);
        chk("mr_first_ready", 32'(ch_ready), 32'b0010);
        ch_valid = 4'b0000;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
